// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, event type and decoder states for the PS/2 scan-code sequencer
package ps2_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam logic [7:0] PS2_PAUSE      = 8'hE1;
   localparam logic [7:0] PS2_OVR0       = 8'h00;
   localparam logic [7:0] PS2_OVR1       = 8'hFF;
   localparam logic [7:0] PS2_BAT        = 8'hAA;
   localparam logic [7:0] PS2_ACK        = 8'hFA;
   localparam logic [7:0] PS2_RESEND     = 8'hFE;
   localparam int         PS2_PAUSE_SKIP = 7;

   // "release" is a reserved word, hence is_release
   typedef struct packed {
      logic       is_release;
      logic       extended;
      logic [7:0] code;
   } ps2_event_t;

   typedef enum logic [2:0] {
      DEC_IDLE,
      DEC_EXT,
      DEC_BRK,
      DEC_EXT_BRK,
      DEC_PAUSE
   } ps2_dec_state_t;

   function automatic logic is_ovr_byte(input logic [7:0] b);
      return (b == PS2_OVR0) || (b == PS2_OVR1);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous event FIFO; head entry presented combinationally, zero when empty
module ps2_event_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic [9:0],
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   output T                 rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a pop frees the slot in the same cycle, so a full FIFO still takes a push
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? T'('0) : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - Set-2 prefix decoder feeding an event FIFO with irq; PS2_TYPEMATIC_FILTER_EN adds repeat suppression
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter int  DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_valid,
   input  logic [7:0]       frame_data,
   output logic             frame_ready,
   output logic             event_valid,
   output logic [9:0]       event_data,
   input  logic             event_ready,
   output logic [CNT_W-1:0] fill_level,
   output logic             overflow,
   input  logic             overflow_clr,
   output logic             irq
);

   ps2_dec_state_t state, state_n;
   logic [2:0]     skip_cnt, skip_n;
   logic           hs;
   logic           push_req;
   ps2_event_t     push_ev;
   ps2_event_t     head;
   logic           ovr_dec;
   logic           fifo_push;
   logic           fifo_full;
   logic           fifo_empty;
   logic           drop;

   assign frame_ready = ~rst;
   assign hs          = frame_valid & frame_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DEC_IDLE;
         skip_cnt <= '0;
      end else begin
         state    <= state_n;
         skip_cnt <= skip_n;
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic pause_ev;
`endif

   always_comb begin
      state_n  = state;
      skip_n   = skip_cnt;
      push_req = 1'b0;
      push_ev  = '0;
      ovr_dec  = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      pause_ev = 1'b0;
`endif
      push_ev.code = frame_data;
      if (hs) begin
         case (state)
            DEC_IDLE: begin
               if (frame_data == PS2_EXT) state_n = DEC_EXT;
               else if (frame_data == PS2_BRK) state_n = DEC_BRK;
               else if (frame_data == PS2_PAUSE) begin
                  state_n = DEC_PAUSE;
                  skip_n  = 3'(PS2_PAUSE_SKIP);
               end else if (is_ovr_byte(frame_data)) ovr_dec = 1'b1;
               else if (!(frame_data == PS2_BAT || frame_data == PS2_ACK ||
                          frame_data == PS2_RESEND)) push_req = 1'b1;
            end
            DEC_EXT: begin
               if (frame_data == PS2_BRK) state_n = DEC_EXT_BRK;
               else if (frame_data != PS2_EXT) begin
                  state_n = DEC_IDLE;
                  if (is_ovr_byte(frame_data)) ovr_dec = 1'b1;
                  else begin
                     push_req         = 1'b1;
                     push_ev.extended = 1'b1;
                  end
               end
            end
            DEC_BRK, DEC_EXT_BRK: begin
               state_n = DEC_IDLE;
               if (is_ovr_byte(frame_data)) ovr_dec = 1'b1;
               else begin
                  push_req           = 1'b1;
                  push_ev.is_release = 1'b1;
                  push_ev.extended   = (state == DEC_EXT_BRK);
               end
            end
            DEC_PAUSE: begin
               // the E1 sequence is 8 bytes; the 7 trailing bytes are swallowed unchecked
               skip_n = skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) begin
                  state_n          = DEC_IDLE;
                  push_req         = 1'b1;
                  push_ev.extended = 1'b1;
                  push_ev.code     = PS2_PAUSE;
`ifdef PS2_TYPEMATIC_FILTER_EN
                  pause_ev         = 1'b1;
`endif
               end
            end
            default: state_n = DEC_IDLE;
         endcase
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [511:0] pressed;
   logic [8:0]   key_idx;

   assign key_idx   = {push_ev.extended, push_ev.code};
   assign fifo_push = push_req & ~(~pause_ev & ~push_ev.is_release & pressed[key_idx]);

   // tracks key state independent of whether the FIFO accepted the event
   always_ff @(posedge clk) begin
      if (rst) pressed <= '0;
      else if (push_req && !pause_ev) pressed[key_idx] <= ~push_ev.is_release;
   end
`else
   assign fifo_push = push_req;
`endif

   ps2_event_fifo #(.DEPTH(DEPTH), .T(ps2_event_t)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_ev),
      .pop       (event_ready),
      .rd_data   (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fill_level)
   );

   assign drop        = fifo_push & fifo_full & ~(event_ready & ~fifo_empty);
   assign event_valid = ~fifo_empty;
   assign event_data  = head;
   assign irq         = event_valid | overflow;

   always_ff @(posedge clk) begin
      if (rst) overflow <= 1'b0;
      else if (ovr_dec || drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - randomized and directed self-checking bench for ps2_kbd_ctrl against a queue-based model
module tb_ps2_kbd_ctrl;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             frame_valid = 1'b0;
   logic [7:0]       frame_data = '0;
   logic             frame_ready;
   logic             event_valid;
   logic [9:0]       event_data;
   logic             event_ready = 1'b0;
   logic [CNT_W-1:0] fill_level;
   logic             overflow;
   logic             overflow_clr = 1'b0;
   logic             irq;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 1'b0;

   ps2_kbd_ctrl #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data),
      .frame_ready  (frame_ready),
      .event_valid  (event_valid),
      .event_data   (event_data),
      .event_ready  (event_ready),
      .fill_level   (fill_level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: prefix flags plus a plain queue of 10-bit events
   int m_q[$];
   bit m_ext, m_brk, m_ovr, m_set, m_pause_ev, m_pop;
   int m_pause, m_ev, m_b, m_idx;
   bit m_pressed [512];

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_ext = 0; m_brk = 0; m_pause = 0; m_ovr = 0;
         foreach (m_pressed[i]) m_pressed[i] = 0;
      end else begin
         m_set = 0; m_ev = -1; m_pause_ev = 0;
         m_pop = event_ready && (m_q.size() > 0);
         if (frame_valid) begin
            m_b = int'(frame_data);
            if (m_pause > 0) begin
               m_pause--;
               if (m_pause == 0) begin m_ev = 'h1E1; m_pause_ev = 1; end
            end else if (m_b == 'h00 || m_b == 'hFF) begin
               m_set = 1; m_ext = 0; m_brk = 0;
            end else if (m_brk) begin
               m_ev = 512 + (m_ext ? 256 : 0) + m_b; m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
               if (m_b == 'hF0) m_brk = 1;
               else if (m_b != 'hE0) begin m_ev = 256 + m_b; m_ext = 0; end
            end else begin
               case (m_b)
                  'hE0: m_ext = 1;
                  'hF0: m_brk = 1;
                  'hE1: m_pause = 7;
                  'hAA, 'hFA, 'hFE: ;
                  default: m_ev = m_b;
               endcase
            end
         end
`ifdef PS2_TYPEMATIC_FILTER_EN
         if (m_ev >= 0 && !m_pause_ev) begin
            m_idx = m_ev % 512;
            if (m_ev < 512) begin
               if (m_pressed[m_idx]) m_ev = -1;
               else m_pressed[m_idx] = 1;
            end else m_pressed[m_idx] = 0;
         end
`endif
         if (m_pop) void'(m_q.pop_front());
         if (m_ev >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_ev);
            else m_set = 1;
         end
         if (m_set) m_ovr = 1;
         else if (overflow_clr) m_ovr = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("frame_ready", int'(frame_ready), rst ? 0 : 1);
         chk("event_valid", int'(event_valid), (m_q.size() > 0) ? 1 : 0);
         chk("event_data", int'(event_data), (m_q.size() > 0) ? m_q[0] : 0);
         chk("fill_level", int'(fill_level), m_q.size());
         chk("overflow", int'(overflow), int'(m_ovr));
         chk("irq", int'(irq), ((m_q.size() > 0) || m_ovr) ? 1 : 0);
      end
   end

   task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c, input bit rs);
      @(negedge clk);
      #1;
      frame_valid  = v;
      frame_data   = d;
      event_ready  = r;
      overflow_clr = c;
      rst          = rs;
   endtask

   task automatic settle();
      cyc(0, 8'h00, 0, 0, 0);
   endtask

   task automatic send(input logic [7:0] d);
      cyc(1, d, 0, 0, 0);
   endtask

   task automatic pop1();
      cyc(0, 8'h00, 1, 0, 0);
      settle();
   endtask

   logic [7:0] specials [10] = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'h1C, 8'h75};

   initial begin
      @(posedge clk);
      #1 cmp_en = 1'b1;
      chk("rst_frame_ready", int'(frame_ready), 0);
      chk("rst_event_valid", int'(event_valid), 0);
      chk("rst_irq", int'(irq), 0);
      repeat (2) @(posedge clk);
      settle();
      chk("post_rst_fill", int'(fill_level), 0);

      send(8'h1C); send(8'hF0); send(8'h1C); settle();
      chk("make_break_fill", int'(fill_level), 2);
      chk("make_data", int'(event_data), 'h01C);
      pop1();
      chk("break_data", int'(event_data), 'h21C);
      pop1();
      chk("drained_irq", int'(irq), 0);

      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); settle();
      chk("ext_fill", int'(fill_level), 2);
      chk("ext_make", int'(event_data), 'h175);
      pop1();
      chk("ext_break", int'(event_data), 'h375);
      pop1();

      foreach (specials[i]) if (i < 0) send(specials[i]);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h1C); settle();
      chk("pause_fill", int'(fill_level), 2);
      chk("pause_data", int'(event_data), 'h1E1);
      pop1();
      chk("after_pause", int'(event_data), 'h01C);
      pop1();

      for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
      settle();
      chk("full_fill", int'(fill_level), 8);
      chk("full_ovr", int'(overflow), 1);
      chk("full_head", int'(event_data), 'h010);
      cyc(1, 8'h20, 1, 0, 0); settle();
      chk("full_pushpop_fill", int'(fill_level), 8);
      for (int i = 1; i < 8; i++) begin
         chk("full_order", int'(event_data), 'h010 + i);
         pop1();
      end
      chk("full_last", int'(event_data), 'h020);
      pop1();
      chk("full_drained", int'(event_valid), 0);

      cyc(0, 8'h00, 0, 1, 0); settle();
      chk("ovr_cleared", int'(overflow), 0);
      send(8'hFF); settle();
      chk("ff_ovr", int'(overflow), 1);
      chk("ff_no_event", int'(fill_level), 0);
      chk("ff_irq", int'(irq), 1);
      cyc(0, 8'h00, 0, 1, 0); settle();

      send(8'hE0); cyc(0, 8'h00, 0, 0, 1); settle();
      send(8'h75); settle();
      chk("rst_mid_seq", int'(event_data), 'h075);
      pop1();

      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C); settle();
`ifdef PS2_TYPEMATIC_FILTER_EN
      chk("typematic_fill", int'(fill_level), 3);
`else
      chk("typematic_fill", int'(fill_level), 5);
`endif
      for (int i = 0; i < 6; i++) pop1();

      for (int n = 0; n < 3000; n++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 9) < 4) ? specials[$urandom_range(0, 9)] : 8'($urandom);
         cyc($urandom_range(0, 9) < 6, d, $urandom_range(0, 1) == 1,
             $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
      end
      settle();
      settle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Scan-code sequencer between the PS/2 frame receiver and the CPU-facing peripheral.
- Consumes raw 8-bit frames over a valid/ready handshake.
- Decodes Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events.
- Buffers events in a FIFO and raises an interrupt, so software reads one event per key action and never sees prefixes.

Parameters:
DEPTH, 8, event FIFO depth in entries; power of two, ≥2.
CNT_W, $clog2(DEPTH+1), width of fill-level output; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_valid  in  1  receiver has a frame
frame_data  in  8  received byte
frame_ready  out  1  controller accepts frame
event_valid  out  1  FIFO non-empty
event_data  out  10  head event: [9]=release, [8]=extended, [7:0]=code
event_ready  in  1  consumer pops head event
fill_level  out  CNT_W  FIFO occupancy
overflow  out  1  sticky: event dropped, or receiver overrun byte seen
overflow_clr  in  1  clears overflow
irq  out  1  event_valid | overflow

Behaviour:
- Reset values: frame_ready=0, event_valid=0, event_data=0, fill_level=0, overflow=0, irq=0. Decoder returns to IDLE; FIFO is emptied.
- frame_ready=1 in every non-reset cycle. Each frame is consumed in its handshake cycle.
- Latency: a completing frame handshake in cycle N gives event_valid=1 in cycle N+1 when the FIFO was empty.
- Decoder FSM (one transition per accepted frame):
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → PAUSE; load skip counter with 7.
    - 00 or FF → set overflow, stay IDLE.
    - AA, FA, FE → discard, stay IDLE.
    - Any other byte → push {0,0,byte}, stay IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay EXT.
    - 00/FF → set overflow, go to IDLE.
    - Any other byte → push {0,1,byte}, go to IDLE.
  - BRK:
    - 00/FF → set overflow, go to IDLE.
    - Any other byte (including prefixes) → push {1,0,byte}, go to IDLE.
  - EXT_BRK:
    - 00/FF → set overflow, go to IDLE.
    - Any other byte → push {1,1,byte}, go to IDLE.
  - PAUSE:
    - Each frame decrements the skip counter.
    - The frame that brings it to 0 pushes {0,1,8'hE1} and goes to IDLE.
    - Byte contents are ignored; 00/FF are not checked here.
- FIFO rules:
  - Push when full without a simultaneous pop: event dropped, overflow set, FSM still advances.
  - Push and pop in the same cycle while full: both succeed; fill_level unchanged.
  - Pop when empty: ignored.
  - fill_level counts 0..DEPTH; the pointers wrap modulo DEPTH.
  - event_data holds the head entry and is stable while event_valid=1 and event_ready=0.
- Overflow flag:
  - overflow_clr and a same-cycle set: set wins.
  - overflow clears only on overflow_clr or rst.
- No frame activity: FSM holds its state indefinitely; there is no timeout.

Optional Feature:
Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Keeps a 512-bit pressed bitmap indexed {extended, code}, cleared on rst.
  - A make event whose bit is already set is discarded (typematic repeat suppressed).
  - Otherwise a make event sets the bit; a break event clears it.
  - The bitmap updates even if the FIFO push is dropped.
  - The pause event is never filtered.
- Not defined: every make event is pushed, and no bitmap logic is synthesised.

Decomposition:
Package ps2_pkg holds:
- Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_OVR0=8'h00, PS2_OVR1=8'hFF, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_PAUSE_SKIP=7.
- Packed struct ps2_event_t {release, extended, code[7:0]}.
- FSM state enum ps2_dec_state_t.

One sub-module, ps2_event_fifo: synchronous FIFO parameterised by DEPTH and element type, with full/empty/count outputs.

Test Plan:
- Frames 1C; F0 1C, event_ready=1 → events 0x01C then 0x21C; irq high only while an event is queued.
- Frames E0 75; E0 F0 75 → events 0x175 then 0x375; no prefix-only events.
- Frames E1 14 77 E1 F0 14 F0 77 → exactly one event 0x1E1; next frame 1C gives 0x01C.
- event_ready=0, 9 make frames with DEPTH=8 → fill_level=8, overflow=1, first 8 codes retained in order. Then pop plus push in the same cycle while full → fill_level stays 8.
- Frame FF in IDLE → overflow=1, no event. overflow_clr → overflow=0. rst after E0 → next byte 75 gives event 0x075.
- With PS2_TYPEMATIC_FILTER_EN: frames 1C 1C 1C F0 1C 1C → events 0x01C, 0x21C, 0x01C.
